vga_sync_rx: RTL and testbench
==============================

# vga_sync_rx

Video timing receiver for the 640x480 @ 800x524 raster. It consumes the active-low hsync/vsync pair produced by our sync generator and recovers the pixel coordinates x/y and the video_on window in the same clock domain. It then verifies every subsequent sync edge against the expected raster position and reports lock status and timing errors. It sits on the sink side of the sync interface: frame-capture, overlay and test-pattern-check blocks use it to recover the raster from sync alone.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_SYNC_START, 656: h count at which hsync goes low
- H_TOTAL, 800: clocks per line
- V_ACTIVE, 480: visible lines per frame
- V_SYNC_START, 491: v count at which vsync goes low
- V_TOTAL, 524: lines per frame
- clk  in  1  pixel clock, one pixel per rising edge; same clock as the sync source
- rst  in  1  asynchronous, active-low reset
- hsync  in  1  active-low horizontal sync, synchronous to clk
- vsync  in  1  active-low vertical sync, synchronous to clk
- x  out  10  recovered column; rh when rh<H_ACTIVE and locked, else 0
- y  out  10  recovered row; rv when rv<V_ACTIVE and locked, else 0
- video_on  out  1  locked && rh<H_ACTIVE && rv<V_ACTIVE
- locked  out  1  raster verified, high in LOCKED
- frame_start  out  1  one-cycle pulse when locked && rh==0 && rv==0
- sync_err  out  1  one-cycle pulse on any sync-position mismatch in H_ALIGN, V_CHECK or LOCKED
- err_cnt  out  8  saturating count of sync_err pulses (sticks at 255)

## Operation
- Internal registers: hs_q and vs_q (previous samples, reset 1); rh and rv (10-bit, reset 0); state.
- hfall = hs_q && !hsync. vfall = vs_q && !vsync.
- Counters, outside SEARCH: rh wraps H_TOTAL-1→0; on the wrap, rv increments and wraps V_TOTAL-1→0. Counters load only as listed below.
- Horizontal expectation: hfall iff rh==H_SYNC_START. Either half failing is an h-mismatch, so a missing edge and an extra edge both fail.
- Vertical expectation: vfall iff rh==0 && rv==V_SYNC_START. Either half failing is a v-mismatch.
- State machine:
  - SEARCH: rh and rv hold. On hfall, load rh←H_SYNC_START+1 and go to H_ALIGN.
  - H_ALIGN: an h-mismatch pulses sync_err, reloads per SEARCH rules (rh←H_SYNC_START+1 if hfall this cycle, else go to SEARCH). On vfall with rh==0, load rv←V_SYNC_START and go to V_CHECK. On vfall with rh≠0, pulse sync_err and go to SEARCH.
  - V_CHECK: on the next vfall with no h/v-mismatch, go to LOCKED. Any mismatch pulses sync_err and goes to SEARCH.
  - LOCKED: any h- or v-mismatch pulses sync_err, drops locked and goes to SEARCH.
- When leaving to SEARCH without an hfall, rh and rv reset to 0.
- When hfall and vfall occur in the same cycle, h-check is evaluated first. An h-mismatch takes priority and only one sync_err pulse is issued.
- err_cnt increments on each sync_err. It saturates at 255 and clears only on reset.

## Timing
- Reset (rst low, asynchronous): state SEARCH, rh=rv=0, hs_q=vs_q=1, x=y=0, video_on=0, locked=0, frame_start=0, sync_err=0, err_cnt=0.
- Zero-latency alignment: once locked, rh/rv equal the source generator's internal counters in the same cycle. x, y and video_on are combinational from rh, rv and state.
- Lock acquisition from a clean stream: the first hfall, then the first vfall, then one full frame verified. locked rises in the cycle after the second vfall.
- sync_err is registered: it asserts the cycle after the mismatching sample. locked falls on that same cycle.
- Reset released mid-frame: reacquire normally. No error is counted while in SEARCH.

## Structure
- vga_timing_pkg: the six raster constants (shared with the generator) and the state enum {SEARCH, H_ALIGN, V_CHECK, LOCKED}.
- One sub-module, sync_edge_det: registers the sync input (reset value 1) and outputs its fall pulse. It is instantiated for hsync and for vsync.
- The top level holds the counters, the state machine, the checks and the error counter.

## Test plan
- Drive from the generator after a common reset. locked rises after the second vfall. Then x==rh, y==rv, and video_on matches the generator every cycle for 3 frames. err_cnt stays 0.
- Start the receiver 12345 clocks into the frame. It locks within 2 frames and stays aligned cycle-exact.
- Delay one hsync fall by 1 clock (rh=657) in LOCKED. sync_err pulses once, locked drops, the receiver reacquires within 2 frames, and err_cnt=1.
- Suppress one vsync pulse in LOCKED. At rh==0, rv==491 a v-mismatch occurs: sync_err pulses, locked drops, and err_cnt increments.
- Inject 300 spurious hsync glitches. err_cnt saturates at 255, and no wrap occurs.
- Pull rst low mid-line while locked. All outputs are 0 immediately with no clock edge, and the receiver relocks after release.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Raster constants shared with the sync generator
// and the receiver state encoding.
package vga_timing_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int H_SYNC_START = 656;
    localparam int H_TOTAL      = 800;
    localparam int V_ACTIVE     = 480;
    localparam int V_SYNC_START = 491;
    localparam int V_TOTAL      = 524;

    typedef enum logic [1:0] {
        SEARCH,
        H_ALIGN,
        V_CHECK,
        LOCKED
    } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Registers one active-low sync line and flags
// the clock in which it first goes low.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic fall
);

    logic q;

    // previous sample; idle-high so reset never fakes an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= 1'b1;
        else      q <= sync_in;
    end

    assign fall = q & ~sync_in;

endmodule

// File: rtl/vga_sync_rx.sv
// Recovers x/y/video_on from hsync/vsync alone and
// keeps checking every sync edge against the raster.
module vga_sync_rx
    import vga_timing_pkg::*;
#(
    parameter int H_ACT = H_ACTIVE,
    parameter int H_SS  = H_SYNC_START,
    parameter int H_TOT = H_TOTAL,
    parameter int V_ACT = V_ACTIVE,
    parameter int V_SS  = V_SYNC_START,
    parameter int V_TOT = V_TOTAL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err,
    output logic [7:0] err_cnt
);

    localparam logic [9:0] HA      = 10'(H_ACT);
    localparam logic [9:0] HSS     = 10'(H_SS);
    localparam logic [9:0] HT_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] VA      = 10'(V_ACT);
    localparam logic [9:0] VSS     = 10'(V_SS);
    localparam logic [9:0] VT_LAST = 10'(V_TOT - 1);

    logic       hfall;
    logic       vfall;
    rx_state_t  state;
    rx_state_t  state_n;
    logic [9:0] rh;
    logic [9:0] rv;
    logic [9:0] rh_n;
    logic [9:0] rv_n;
    logic [9:0] rh_inc;
    logic [9:0] rv_inc;
    logic       h_mis;
    logic       v_mis;
    logic       err_n;

    sync_edge_det u_hs (
        .clk     (clk),
        .rst     (rst),
        .sync_in (hsync),
        .fall    (hfall)
    );

    sync_edge_det u_vs (
        .clk     (clk),
        .rst     (rst),
        .sync_in (vsync),
        .fall    (vfall)
    );

    // raster position one clock ahead, wrapping line then frame
    always_comb begin
        rh_inc = (rh == HT_LAST) ? '0 : rh + 10'd1;
        rv_inc = rv;
        if (rh == HT_LAST) begin
            rv_inc = (rv == VT_LAST) ? '0 : rv + 10'd1;
        end
    end

    // an edge where none is expected, or none where one is, both miss
    assign h_mis = hfall ^ (rh == HSS);
    assign v_mis = vfall ^ ((rh == '0) && (rv == VSS));

    // lock state machine, counter loads and mismatch detection
    always_comb begin
        state_n = state;
        rh_n    = rh;
        rv_n    = rv;
        err_n   = 1'b0;
        unique case (state)
            SEARCH: begin
                if (hfall) begin
                    state_n = H_ALIGN;
                    rh_n    = HSS + 10'd1;
                end
            end
            H_ALIGN: begin
                if (h_mis) begin
                    err_n = 1'b1;
                end else if (vfall) begin
                    if (rh == '0) begin
                        state_n = V_CHECK;
                        rh_n    = rh_inc;
                        rv_n    = VSS;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    rh_n = rh_inc;
                    rv_n = rv_inc;
                end
            end
            V_CHECK, LOCKED: begin
                if (h_mis || v_mis) begin
                    err_n = 1'b1;
                end else begin
                    rh_n = rh_inc;
                    rv_n = rv_inc;
                    if (vfall) state_n = LOCKED;
                end
            end
        endcase
        // restart acquisition, reusing this cycle's hsync edge if any
        if (err_n) begin
            rv_n = '0;
            if (hfall) begin
                state_n = H_ALIGN;
                rh_n    = HSS + 10'd1;
            end else begin
                state_n = SEARCH;
                rh_n    = '0;
            end
        end
    end

    // state and raster counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEARCH;
            rh    <= '0;
            rv    <= '0;
        end else begin
            state <= state_n;
            rh    <= rh_n;
            rv    <= rv_n;
        end
    end

    // registered error pulse and saturating error count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            sync_err <= err_n;
            if (err_n && (err_cnt != 8'hff)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign locked      = (state == LOCKED);
    assign video_on    = locked && (rh < HA) && (rv < VA);
    assign x           = (locked && (rh < HA)) ? rh : '0;
    assign y           = (locked && (rv < VA)) ? rv : '0;
    assign frame_start = locked && (rh == '0) && (rv == '0);

endmodule

// File: tb/tb_vga_sync_rx.sv
// Randomised self-checking bench for vga_sync_rx on a
// scaled-down raster driven by an in-bench sync generator.
module tb_vga_sync_rx;

    localparam int HA  = 32;
    localparam int HSS = 33;
    localparam int HSW = 4;
    localparam int HT  = 40;
    localparam int VA  = 15;
    localparam int VSS = 16;
    localparam int VSW = 2;
    localparam int VT  = 20;
    localparam int FR  = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       locked;
    logic       frame_start;
    logic       sync_err;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    int gh = 0;
    int gv = 0;
    bit del_h = 1'b0;
    bit sup_v = 1'b0;
    bit glitch = 1'b0;

    int m_st = 0;
    int m_rh = 0;
    int m_rv = 0;
    bit m_hs = 1'b1;
    bit m_vs = 1'b1;
    bit m_err = 1'b0;
    int m_cnt = 0;

    vga_sync_rx #(
        .H_ACT (HA),
        .H_SS  (HSS),
        .H_TOT (HT),
        .V_ACT (VA),
        .V_SS  (VSS),
        .V_TOT (VT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hsync       (hsync),
        .vsync       (vsync),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .locked      (locked),
        .frame_start (frame_start),
        .sync_err    (sync_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s: got %0d expected %0d (gen h=%0d v=%0d)",
                         name, act, exp, gh, gv);
        end
    endtask

    task automatic drive();
        hsync = !(gh >= HSS && gh < HSS + HSW);
        if (del_h && gh == HSS) hsync = 1'b1;
        if (glitch) hsync = 1'b0;
        vsync = sup_v ? 1'b1 : !(gv >= VSS && gv < VSS + VSW);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        gh = gh + 1;
        if (gh == HT) begin
            gh = 0;
            gv = (gv + 1) % VT;
        end
        drive();
    endtask

    task automatic model_reset();
        m_st = 0;
        m_rh = 0;
        m_rv = 0;
        m_hs = 1'b1;
        m_vs = 1'b1;
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    // 0 searching, 1 line found, 2 frame found, 3 verified
    task automatic model_step();
        bit hf, vf, hm, vm, bad;
        int nh, nv;
        hf = m_hs && !hsync;
        vf = m_vs && !vsync;
        m_hs = hsync;
        m_vs = vsync;
        hm = hf != (m_rh == HSS);
        vm = vf != (m_rh == 0 && m_rv == VSS);
        nh = (m_rh + 1) % HT;
        nv = (m_rh == HT - 1) ? (m_rv + 1) % VT : m_rv;
        bad = 1'b0;
        if (m_st == 0) begin
            if (hf) begin
                m_st = 1;
                m_rh = HSS + 1;
            end
        end else if (m_st == 1) begin
            if (hm || (vf && m_rh != 0)) bad = 1'b1;
            else if (vf) begin
                m_st = 2;
                m_rh = nh;
                m_rv = VSS;
            end else begin
                m_rh = nh;
                m_rv = nv;
            end
        end else begin
            if (hm || vm) bad = 1'b1;
            else begin
                if (vf) m_st = 3;
                m_rh = nh;
                m_rv = nv;
            end
        end
        m_err = bad;
        if (bad) begin
            if (m_cnt < 255) m_cnt++;
            m_rv = 0;
            m_st = hf ? 1 : 0;
            m_rh = hf ? HSS + 1 : 0;
        end
    endtask

    // single compare point: model every cycle, generator when locked
    always @(negedge clk) begin
        if (!rst) begin
            model_reset();
        end else begin
            chk("locked", locked, m_st == 3);
            chk("x", x, (m_st == 3 && m_rh < HA) ? m_rh : 0);
            chk("y", y, (m_st == 3 && m_rv < VA) ? m_rv : 0);
            chk("video_on", video_on, m_st == 3 && m_rh < HA && m_rv < VA);
            chk("frame_start", frame_start, m_st == 3 && m_rh == 0 && m_rv == 0);
            chk("sync_err", sync_err, m_err);
            chk("err_cnt", err_cnt, m_cnt);
            if (locked) begin
                chk("x_gen", x, gh < HA ? gh : 0);
                chk("y_gen", y, gv < VA ? gv : 0);
                chk("von_gen", video_on, gh < HA && gv < VA);
            end
            model_step();
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_von"}, video_on, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_err"}, sync_err, 0);
        chk({tag, "_cnt"}, err_cnt, 0);
    endtask

    task automatic wait_lock(input string name, input int budget);
        int n;
        n = 0;
        while (!locked && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_relock"}, locked, 1);
    endtask

    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        while (!(gh == h && (v < 0 || gv == v)) && n < FR + 1) begin
            tick();
            n++;
        end
        chk("wait_pos", gh == h && (v < 0 || gv == v), 1);
    endtask

    initial begin
        int n, fs, von, e0, eh, ev;
        bit seen_err, seen_unlock;

        drive();
        #2;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // clean stream from a common reset
        n = 0;
        while (!locked && n < 3 * FR) begin
            tick();
            n++;
        end
        chk("lock_latency", n, VSS * HT + FR + 1);
        fs = 0;
        von = 0;
        for (int i = 0; i < 3 * FR; i++) begin
            tick();
            if (frame_start) fs++;
            if (video_on) von++;
        end
        chk("frame_starts", fs, 3);
        chk("video_on_cycles", von, 3 * HA * VA);
        chk("clean_err_cnt", err_cnt, 0);

        // one hsync fall arrives a clock late
        wait_pos(0, -1);
        e0 = err_cnt;
        del_h = 1'b1;
        seen_err = 1'b0;
        while (gh != HSS + 2) begin
            tick();
            if (sync_err) seen_err = 1'b1;
        end
        del_h = 1'b0;
        chk("late_h_unlock", locked, 0);
        chk("late_h_err_seen", seen_err, 1);
        wait_lock("late_h", 2 * FR + HT);
        chk("late_h_cnt_up", err_cnt > e0, 1);

        // one vsync pulse missing
        wait_pos(0, VSS - 1);
        e0 = err_cnt;
        sup_v = 1'b1;
        eh = -1;
        ev = -1;
        seen_unlock = 1'b0;
        while (!(gh == 0 && gv == VSS + VSW)) begin
            tick();
            if (sync_err && eh < 0) begin
                eh = gh;
                ev = gv;
            end
            if (!locked) seen_unlock = 1'b1;
        end
        sup_v = 1'b0;
        chk("no_v_err_h", eh, 1);
        chk("no_v_err_v", ev, VSS);
        chk("no_v_unlock", seen_unlock, 1);
        wait_lock("no_v", 2 * FR + HT);
        chk("no_v_cnt_delta", err_cnt - e0, 1);

        // burst of spurious hsync glitches
        for (int g = 0; g < 300; g++) begin
            repeat ($urandom_range(24, 8)) tick();
            glitch = 1'b1;
            tick();
            glitch = 1'b0;
        end
        repeat (4) tick();
        chk("glitch_saturate", err_cnt, 255);
        wait_lock("glitch", 3 * FR);
        chk("glitch_still_sat", err_cnt, 255);

        // asynchronous reset in the middle of a locked line
        wait_pos(10, -1);
        chk("pre_rst_locked", locked, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        repeat (300 + $urandom_range(90, 0)) tick();
        rst = 1'b1;
        wait_lock("midframe", 2 * FR);
        repeat (FR) tick();
        chk("midframe_err_cnt", err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
